// File: rtl/dac_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dac_serializer
// Desc     : Buffers 10-bit filter samples in a 4-entry FIFO and ships each
//            one to an SPI DAC as a 16-bit frame {CMD, sample, 2'b00}.
//            The DAC samples MOSI on sclk rising edges, and MOSI changes on
//            sclk falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module dac_serializer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_GAP  = 2,
  parameter logic [3:0]  CMD     = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] y_n,
  input  logic       valid_out,
  input  logic       overflow_clr,
  output logic       dac_sclk,
  output logic       dac_mosi,
  output logic       dac_cs_n,
  output logic [2:0] fifo_level,
  output logic       busy,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [2:0] DEPTH    = 3'd4;

  // FIFO storage and bookkeeping
  logic [9:0]  mem_q [4];
  logic [1:0]  wr_ptr_q;
  logic [1:0]  rd_ptr_q;
  logic [2:0]  count_q;
  logic [2:0]  count_d;
  logic        ovf_q;

  // Frame sequencer state
  state_t      state_q;
  logic [7:0]  div_q;
  logic [7:0]  gap_q;
  logic [3:0]  fall_q;
  logic [14:0] shreg_q;     // bits still to be sent; bit 15 goes straight to MOSI
  logic        sclk_q;
  logic        mosi_q;
  logic        cs_n_q;
  logic        busy_q;

  logic        pop_d;
  logic        push_d;
  logic        drop_d;
  logic [15:0] frame_d;

  // A new frame starts from IDLE, or directly from the last GAP cycle so that
  // back-to-back frames see exactly CS_GAP high cycles on cs_n.
  always_comb begin
    pop_d = 1'b0;
    if (count_q != 3'd0) begin
      if (state_q == S_IDLE) begin
        pop_d = 1'b1;
      end else if ((state_q == S_GAP) && (gap_q == GAP_LAST)) begin
        pop_d = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a sample when a pop frees a slot on the same edge.
  assign push_d  = valid_out && ((count_q != DEPTH) || pop_d);
  assign drop_d  = valid_out && (count_q == DEPTH) && !pop_d;
  assign frame_d = {CMD, mem_q[rd_ptr_q], 2'b00};

  // Occupancy next-state from the push/pop pair
  always_comb begin
    count_d = count_q;
    if (push_d && !pop_d) begin
      count_d = count_q + 3'd1;
    end else if (pop_d && !push_d) begin
      count_d = count_q - 3'd1;
    end
  end

  // Sample storage; contents are don't-care once pointers are reset
  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= y_n;
    end
  end

  // FIFO pointers (wrap naturally at 2 bits), level and sticky overflow flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_d) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop_d)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_d;
      if (drop_d) begin
        ovf_q <= 1'b1;
      end else if (overflow_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Frame sequencer: load a frame, shift 16 bits on sclk falls, then hold cs_n high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      div_q   <= 8'd0;
      gap_q   <= 8'd0;
      fall_q  <= 4'd0;
      shreg_q <= 15'd0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else if (pop_d) begin
      state_q <= S_SHIFT;
      shreg_q <= frame_d[14:0];
      mosi_q  <= frame_d[15];
      cs_n_q  <= 1'b0;
      sclk_q  <= 1'b0;
      div_q   <= 8'd0;
      fall_q  <= 4'd0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
        end
        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= 8'd0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (fall_q == 4'd15) begin
                cs_n_q  <= 1'b1;
                mosi_q  <= 1'b0;
                gap_q   <= 8'd0;
                state_q <= S_GAP;
              end else begin
                fall_q  <= fall_q + 4'd1;
                mosi_q  <= shreg_q[14];
                shreg_q <= {shreg_q[13:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_mosi   = mosi_q;
  assign dac_cs_n   = cs_n_q;
  assign fifo_level = count_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_serializer
// Desc     : Self-checking bench for dac_serializer: directed vector table,
//            hand-written frame/overflow/reset sequences and a randomized run
//            against a timing-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_serializer;

  localparam int         D   = 4;
  localparam int         G   = 2;
  localparam logic [3:0] CMD = 4'b0011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] y_n = 10'd0;
  logic       valid_out = 1'b0;
  logic       overflow_clr = 1'b0;
  logic       dac_sclk;
  logic       dac_mosi;
  logic       dac_cs_n;
  logic [2:0] fifo_level;
  logic       busy;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  dac_serializer #(
    .CLK_DIV (D),
    .CS_GAP  (G),
    .CMD     (CMD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .y_n          (y_n),
    .valid_out    (valid_out),
    .overflow_clr (overflow_clr),
    .dac_sclk     (dac_sclk),
    .dac_mosi     (dac_mosi),
    .dac_cs_n     (dac_cs_n),
    .fifo_level   (fifo_level),
    .busy         (busy),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: frames are described by their start edge; every output
  // follows from the elapsed edge count since that start.
  int          e = 0;
  logic [9:0]  mq[$];
  bit          have_frame = 1'b0;
  int          cur_s = 0;
  logic [15:0] cur_frame = 16'd0;
  int          next_free = 0;
  bit          m_ovf = 1'b0;

  // Monitor of the serial pins
  int          frames, high_run, low_run, rises, sclk_gap_err;
  bit          had_rise, prev_cs_n, prev_sclk;
  int          gaps[$];
  int          lows[$];
  logic [15:0] cap;

  typedef struct {
    bit         v;
    logic [9:0] d;
    bit         c;
    int         lvl;
    bit         ovf;
    bit         cs_n;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pins();
    return int'({dac_cs_n, dac_sclk, dac_mosi, busy, overflow, fifo_level});
  endfunction

  task automatic model_reset();
    mq.delete();
    have_frame = 1'b0;
    next_free  = 0;
    m_ovf      = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [9:0] d, input bit c);
    int sz;
    bit pop;
    e++;
    sz  = mq.size();
    pop = (sz > 0) && (e >= next_free);
    if (pop) begin
      cur_frame  = {CMD, mq.pop_front(), 2'b00};
      cur_s      = e;
      have_frame = 1'b1;
      next_free  = e + 32 * D + G;
    end
    if (v && ((sz < 4) || pop)) mq.push_back(d);
    if (v && (sz == 4) && !pop) m_ovf = 1'b1;
    else if (c)                 m_ovf = 1'b0;
  endtask

  task automatic check_model();
    int         t;
    bit         inf;
    logic [7:0] ex;
    t     = e - cur_s;
    inf   = have_frame && (t < 32 * D);
    ex    = 8'd0;
    ex[7] = !inf;
    if (inf) begin
      ex[6] = ((t / D) % 2) == 1;
      ex[5] = cur_frame[15 - (t / (2 * D))];
    end
    ex[4]   = have_frame && (e < next_free);
    ex[3]   = m_ovf;
    ex[2:0] = 3'(mq.size());
    chk($sformatf("model_edge%0d", e), pins(), int'(ex));
  endtask

  task automatic mon_clear();
    frames = 0; high_run = 0; low_run = 0; rises = 0; sclk_gap_err = 0;
    had_rise = 1'b0; prev_cs_n = dac_cs_n; prev_sclk = dac_sclk;
    gaps.delete(); lows.delete(); cap = 16'd0;
  endtask

  task automatic mon_update();
    if (prev_cs_n && !dac_cs_n) begin
      frames++;
      if (had_rise) gaps.push_back(high_run);
    end
    if (!prev_cs_n && dac_cs_n) begin
      lows.push_back(low_run);
      had_rise = 1'b1;
    end
    if (dac_cs_n) begin
      high_run++;
      low_run = 0;
      if (dac_sclk) sclk_gap_err++;
    end else begin
      low_run++;
      high_run = 0;
      if (!prev_sclk && dac_sclk) begin
        rises++;
        cap = {cap[14:0], dac_mosi};
      end
    end
    prev_cs_n = dac_cs_n;
    prev_sclk = dac_sclk;
  endtask

  task automatic step(input bit v, input logic [9:0] d, input bit c);
    @(negedge clk);
    valid_out    = v;
    y_n          = d;
    overflow_clr = c;
    @(posedge clk);
    model_edge(v, d, c);
    #1;
    check_model();
    mon_update();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    valid_out    = 1'b0;
    overflow_clr = 1'b0;
    reset        = 1'b1;
    #1;
    chk(name, pins(), 8'h80);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step(1'b0, 10'd0, 1'b0);
      done = (fifo_level == 3'd0) && !busy;
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    tbl[0] = '{1'b1, 10'h101, 1'b0, 1, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 10'h102, 1'b0, 1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 10'h103, 1'b0, 2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 10'h104, 1'b0, 3, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 10'h105, 1'b0, 4, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 10'h106, 1'b0, 4, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 10'h000, 1'b0, 4, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 10'h000, 1'b1, 4, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 10'h000, 1'b0, 4, 1'b0, 1'b0};

    do_reset("reset_initial");

    // Burst of six: first accepted on the first edge, sixth dropped
    mon_clear();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), int'(fifo_level), tbl[i].lvl);
      chk($sformatf("tbl%0d_ovf", i),   int'(overflow),   int'(tbl[i].ovf));
      chk($sformatf("tbl%0d_cs_n", i),  int'(dac_cs_n),   int'(tbl[i].cs_n));
    end
    drain("burst_drain");
    chk("burst_frames", frames, 5);
    chk("burst_gap_count", gaps.size(), 4);
    foreach (gaps[i]) chk($sformatf("burst_gap%0d", i), gaps[i], G);
    foreach (lows[i]) chk($sformatf("burst_low%0d", i), lows[i], 32 * D);
    chk("burst_sclk_in_gap", sclk_gap_err, 0);

    // Single sample 0x2A5: latency, bit pattern and cs_n low time
    mon_clear();
    step(1'b1, 10'h2A5, 1'b0);
    chk("single_cs_n_before", int'(dac_cs_n), 1);
    step(1'b0, 10'd0, 1'b0);
    chk("single_latency_cs_n", int'(dac_cs_n), 0);
    drain("single_drain");
    chk("single_bits", int'(cap), 16'h3A94);
    chk("single_rises", rises, 16);
    chk("single_frames", frames, 1);
    chk("single_low_count", lows.size(), 1);
    if (lows.size() > 0) chk("single_low_len", lows[0], 32 * D);
    chk("single_level", int'(fifo_level), 0);

    // Full FIFO with a strobe on the pop edge
    mon_clear();
    for (int i = 0; i < 5; i++) step(1'b1, 10'(10'h200 + i), 1'b0);
    chk("simul_full", int'(fifo_level), 4);
    for (int i = 0; i < 300 && !dac_cs_n; i++) step(1'b0, 10'd0, 1'b0);
    chk("simul_cs_high", int'(dac_cs_n), 1);
    repeat (G - 1) step(1'b0, 10'd0, 1'b0);
    step(1'b1, 10'h3FF, 1'b0);
    chk("simul_level", int'(fifo_level), 4);
    chk("simul_ovf", int'(overflow), 0);
    chk("simul_cs_low", int'(dac_cs_n), 0);
    drain("simul_drain");
    chk("simul_frames", frames, 6);
    chk("simul_ovf_end", int'(overflow), 0);

    // Reset in the middle of a frame after the 7th sclk rise
    for (int i = 0; i < 3; i++) step(1'b1, 10'(10'h055 + i), 1'b0);
    mon_clear();
    for (int i = 0; i < 300 && rises < 7; i++) step(1'b0, 10'd0, 1'b0);
    chk("abort_rise7", rises, 7);
    step(1'b0, 10'd0, 1'b0);
    do_reset("abort_reset");
    mon_clear();
    repeat (300) step(1'b0, 10'd0, 1'b0);
    chk("abort_no_frames", frames, 0);
    chk("abort_level", int'(fifo_level), 0);

    // Randomized traffic at several strobe densities, with one reset
    for (int seg = 0; seg < 8; seg++) begin
      int dens;
      case (seg % 4)
        0:       dens = 2;
        1:       dens = 15;
        2:       dens = 60;
        default: dens = 200;
      endcase
      if (seg == 5) do_reset("random_reset");
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, dens - 1) == 0, 10'($urandom), $urandom_range(0, 149) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_serializer.md
DAC_SERIALIZER -- requirements
Module: dac_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4: dac_sclk half-period in clk cycles; legal range 2..255.
REQ-002 Parameter CS_GAP, default 2: minimum clk cycles dac_cs_n stays high between frames; legal range 1..255.
REQ-003 Parameter CMD, default 4'b0011: 4-bit DAC command field placed in frame bits [15:12].
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 y_n  input  10  filter output sample.
REQ-007 valid_out  input  1  one-cycle strobe; y_n is valid in that cycle.
REQ-008 overflow_clr  input  1  synchronous clear of the overflow flag.
REQ-009 dac_sclk  output  1  serial clock; idle low.
REQ-010 dac_mosi  output  1  serial data, MSB first.
REQ-011 dac_cs_n  output  1  active-low frame select.
REQ-012 fifo_level  output  3  number of samples held, 0..4.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.
REQ-014 overflow  output  1  sticky flag; a sample was dropped.

Function
REQ-015 The block SHALL contain a 4-entry FIFO of 10-bit samples, written on every clk edge where valid_out=1 and a slot is free.
REQ-016 Full FIFO plus valid_out with no pop in the same cycle: the sample SHALL be dropped, FIFO contents unchanged, and overflow set on that edge.
REQ-017 Full FIFO plus valid_out with a pop in the same cycle: the sample SHALL be accepted, fifo_level stays 4, and overflow is not set.
REQ-018 Empty FIFO plus valid_out with a pop in the same cycle cannot occur, because a pop requires a non-empty FIFO; the write SHALL proceed normally.
REQ-019 overflow_clr=1 SHALL clear overflow on the next edge; a simultaneous new drop SHALL win, leaving overflow=1.
REQ-020 FSM states SHALL be IDLE, SHIFT and GAP.
REQ-021 IDLE -> SHIFT when fifo_level>0; on that edge the oldest sample is popped and loaded as frame {CMD, sample[9:0], 2'b00}, dac_cs_n is driven 0, and dac_mosi is driven frame[15].
REQ-022 In SHIFT, a divider counter SHALL toggle dac_sclk every CLK_DIV clk cycles, starting low.
REQ-023 In SHIFT, dac_mosi SHALL update to the next bit only on dac_sclk falling edges, so the DAC samples on rising edges.
REQ-024 After the 16th dac_sclk falling edge, dac_cs_n SHALL go 1, dac_sclk SHALL be 0, and the FSM SHALL enter GAP; total low time of dac_cs_n is exactly 32*CLK_DIV clk cycles.
REQ-025 GAP SHALL last exactly CS_GAP clk cycles, then return to IDLE; consecutive frames are therefore back-to-back with exactly CS_GAP high cycles.
REQ-026 Latency: valid_out at edge N with an empty FIFO in IDLE SHALL give dac_cs_n=0 after edge N+1.
REQ-027 dac_mosi SHALL be 0 outside SHIFT.
REQ-028 All outputs SHALL be registered.
REQ-029 The FIFO read and write pointers SHALL wrap modulo 4.

Reset
REQ-030 While reset=1, the block SHALL immediately drive dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, overflow=0 and fifo_level=0, and hold the FSM in IDLE.
REQ-031 Reset asserted mid-frame SHALL abort the frame without completing it; all FIFO contents are discarded.
REQ-032 After reset deasserts, the first valid_out SHALL be accepted on the first clk edge.

Verification
REQ-033 Single sample: y_n=10'h2A5 strobed once (CLK_DIV=4) -> one frame with MOSI bits 0011_1010100101_00, cs_n low 128 cycles, fifo_level back to 0.
REQ-034 Burst: 5 strobes on consecutive cycles while idle -> 5 frames; first popped immediately, 4 buffered, overflow stays 0.
REQ-035 Overflow: 6 strobes on consecutive cycles -> 6th sample dropped, overflow=1 until overflow_clr, exactly 5 frames sent.
REQ-036 Simultaneous: FIFO full and valid_out on the pop edge -> sample accepted, fifo_level=4, overflow=0.
REQ-037 Reset mid-frame after the 7th sclk rising edge -> cs_n=1 and sclk=0 immediately, fifo_level=0, no further frames.
REQ-038 Back-to-back frames with CS_GAP=2 -> exactly 2 cs_n-high cycles between frames, sclk low throughout the gap.
